bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 tb/tb_bin2bcd_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle, fixed latency.
// Optional macro BIN2BCD_BLANK_EN adds a registered leading-zero blanking output.
`timescale 1ns/1ps
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd,
`ifdef BIN2BCD_BLANK_EN
  output logic [DIGITS-1:0]     blank,
`endif
  output logic                  overflow
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOp   = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q;
  logic [BIN_W-1:0]  op_q;
  logic [CntW-1:0]   cnt_q;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] dig_next;
  logic                carry;

  // Add-3 correction on every digit, then shift the operand MSB into the units digit.
  always_comb begin
    adj = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      adj[4*k +: 4] = (bcd[4*k +: 4] > 4'd4) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    end
    dig_next = {adj[4*DIGITS-2:0], op_q[BIN_W-1]};
    carry    = adj[4*DIGITS-1];
  end

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BlankRst = ~DIGITS'(1);

  logic [DIGITS-1:0] blank_next;

  // Bit k is set when digit k and every digit above it are zero; units digit never blanks.
  always_comb begin
    blank_next = '0;
    blank_next[DIGITS-1] = (dig_next[4*DIGITS-1 -: 4] == 4'd0);
    for (int k = int'(DIGITS) - 2; k >= 1; k--) begin
      blank_next[k] = blank_next[k+1] && (dig_next[4*k +: 4] == 4'd0);
    end
    blank_next[0] = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
      op_q      <= '0;
      cnt_q     <= '0;
`ifdef BIN2BCD_BLANK_EN
      blank     <= BlankRst;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q     <= bin;
            bcd      <= '0;
            overflow <= 1'b0;
            cnt_q    <= CntW'(BIN_W);
            ready    <= 1'b0;
            state_q  <= StOp;
`ifdef BIN2BCD_BLANK_EN
            blank    <= BlankRst;
`endif
          end
        end
        StOp: begin
          bcd      <= dig_next;
          op_q     <= {op_q[BIN_W-2:0], 1'b0};
          overflow <= overflow | carry;
          cnt_q    <= cnt_q - CntW'(1);
`ifdef BIN2BCD_BLANK_EN
          blank    <= blank_next;
`endif
          if (cnt_q == CntW'(1)) begin
            state_q   <= StDone;
            done_tick <= 1'b1;
          end
        end
        StDone: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed vectors at defaults plus a 20-bit/6-digit instance.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start, ready, done_tick, overflow;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        start_w, ready_w, done_w, ovf_w;
  logic [19:0] bin_w;
  logic [23:0] bcd_w;
`ifdef BIN2BCD_BLANK_EN
  logic [3:0]  blank;
  logic [5:0]  blank_w;
`endif

  bin2bcd_seq u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd),
`ifdef BIN2BCD_BLANK_EN
    .blank     (blank),
`endif
    .overflow  (overflow)
  );

  bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) u_dut_w (
    .clk       (clk),
    .reset     (reset),
    .start     (start_w),
    .bin       (bin_w),
    .ready     (ready_w),
    .done_tick (done_w),
    .bcd       (bcd_w),
`ifdef BIN2BCD_BLANK_EN
    .blank     (blank_w),
`endif
    .overflow  (ovf_w)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
    logic [5:0]  blank;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t sb_w[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done_tick) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("bcd", 64'(bcd), 64'(e.bcd[15:0]));
        check("overflow", 64'(overflow), 64'(e.ovf));
        check("latency", 64'(cyc), 64'(e.due));
`ifdef BIN2BCD_BLANK_EN
        check("blank", 64'(blank), 64'(e.blank[3:0]));
`endif
      end
    end
  end

  // Monitor for the wide instance
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done_w) begin
      if (sb_w.size() == 0) begin
        check("unexpected_done_w", 64'(1), 64'(0));
      end else begin
        e = sb_w.pop_front();
        check("bcd_w", 64'(bcd_w), 64'(e.bcd));
        check("overflow_w", 64'(ovf_w), 64'(e.ovf));
        check("latency_w", 64'(cyc), 64'(e.due));
`ifdef BIN2BCD_BLANK_EN
        check("blank_w", 64'(blank_w), 64'(e.blank));
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 64'(ready), 64'(1));
  endtask

  task automatic convert(input logic [13:0] b, input logic [15:0] e_bcd, input logic e_ovf,
                         input logic [3:0] e_blank);
    wait_ready();
    bin   = b;
    start = 1'b1;
    sb.push_back('{bcd: {8'h0, e_bcd}, ovf: e_ovf, blank: {2'b0, e_blank}, due: cyc + 15});
    @(negedge clk);
    start = 1'b0;
    check("ready_low_in_op", 64'(ready), 64'(0));
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || sb_w.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || sb_w.size() != 0)
      check("drain_timeout", 64'(sb.size() + sb_w.size()), 64'(0));
  endtask

  logic [13:0] held_bin [3] = '{14'd1234, 14'd5678, 14'd9876};
  logic [15:0] held_bcd [3] = '{16'h1234, 16'h5678, 16'h9876};

  initial begin
    int prev;
    reset   = 1'b1;
    start   = 1'b0;
    bin     = '0;
    start_w = 1'b0;
    bin_w   = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_done", 64'(done_tick), 64'(0));
    check("rst_bcd", 64'(bcd), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
`ifdef BIN2BCD_BLANK_EN
    check("rst_blank", 64'(blank), 64'(4'b1110));
`endif
    reset = 1'b0;
    @(negedge clk);

    convert(14'd9999, 16'h9999, 1'b0, 4'b0000);
    drain();
    repeat (3) @(negedge clk);
    check("hold_bcd", 64'(bcd), 64'(16'h9999));
    check("hold_ready", 64'(ready), 64'(1));

    convert(14'd16383, 16'h6383, 1'b1, 4'b0000);
    convert(14'd0,     16'h0000, 1'b0, 4'b1110);
    convert(14'd42,    16'h0042, 1'b0, 4'b1100);
    convert(14'd12345, 16'h2345, 1'b1, 4'b0000);
    convert(14'd10000, 16'h0000, 1'b1, 4'b1110);
    convert(14'd1,     16'h0001, 1'b0, 4'b1110);
    convert(14'd8191,  16'h8191, 1'b0, 4'b0000);
    convert(14'd305,   16'h0305, 1'b0, 4'b1000);
    drain();

    // Start held high: back-to-back conversions, bin scrambled mid-OP
    wait_ready();
    start = 1'b1;
    prev  = 0;
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      if (i > 0) check("period", 64'(cyc - prev), 64'(16));
      prev = cyc;
      bin  = held_bin[i];
      sb.push_back('{bcd: {8'h0, held_bcd[i]}, ovf: 1'b0, blank: 6'b0, due: cyc + 15});
      @(negedge clk);
      bin = 14'h3FFF;
      @(negedge clk);
      check("held_ready_low", 64'(ready), 64'(0));
    end
    wait_ready();
    start = 1'b0;
    drain();

    // Reset in the middle of OP
    wait_ready();
    bin   = 14'd1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_ready", 64'(ready), 64'(1));
    check("abort_bcd", 64'(bcd), 64'(0));
    check("abort_ovf", 64'(overflow), 64'(0));
    check("abort_done", 64'(done_tick), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_idle", 64'(ready), 64'(1));
    convert(14'd42, 16'h0042, 1'b0, 4'b1100);
    drain();

    // Wide instance
    for (int i = 0; i < 2; i++) begin
      bin_w   = (i == 0) ? 20'd999999 : 20'd1048575;
      start_w = 1'b1;
      sb_w.push_back('{bcd: (i == 0) ? 24'h999999 : 24'h048575, ovf: (i == 0) ? 1'b0 : 1'b1,
                       blank: (i == 0) ? 6'b000000 : 6'b100000, due: cyc + 21});
      @(negedge clk);
      start_w = 1'b0;
      check("ready_w_low", 64'(ready_w), 64'(0));
      drain();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
